// File: rtl/pxs_tile_render.sv
// Tile renderer: owns the 2048x4 game table and overlays tile glyph colours on the
// 26-bit pixel stream {RGB,XC,YC,HS,VS,Active}. Fixed two-cycle latency.
module pxs_tile_render #(
   parameter int unsigned VISIBLECOLS = 640,
   parameter int unsigned VISIBLEROWS = 480,
   parameter int unsigned TILECOLS    = 40,
   parameter int unsigned TABSIZE     = 1200
) (
   input  logic        px_clk,
   input  logic        rst,
   input  logic [25:0] RGBStr_i,
   input  logic        write_en,
   input  logic [10:0] TabAdd,
   input  logic [3:0]  TabDat,
   output logic [25:0] RGBStr_o
);

   logic [9:0]  w_xc;
   logic [9:0]  w_yc;
   logic [5:0]  w_trow;
   logic [5:0]  w_tcol;
   logic [10:0] w_rd_addr;
   logic        w_oor;
   logic        w_wr_ok;

   assign w_xc    = RGBStr_i[22:13];
   assign w_yc    = RGBStr_i[12:3];
   assign w_tcol  = w_xc[9:4];
   assign w_trow  = w_yc[9:4];
   assign w_oor   = ({22'd0, w_xc} >= VISIBLECOLS) || ({22'd0, w_yc} >= VISIBLEROWS);
   assign w_wr_ok = write_en && ({21'd0, TabAdd} < TABSIZE);

   // Row*TILECOLS as a sum of shifted rows, one term per set bit (40 -> r<<5 + r<<3).
   always_comb begin
      w_rd_addr = {5'd0, w_tcol};
      for (int b = 0; b < 6; b++) begin
         if (TILECOLS[b]) begin
            w_rd_addr = w_rd_addr + ({5'd0, w_trow} << b);
         end
      end
   end

   // Game table: not reset; the read register returns the pre-write value on collision.
   logic [3:0] r_tab [2048];
   logic [3:0] r_code;

   always_ff @(posedge px_clk) begin
      if (w_wr_ok) begin
         r_tab[TabAdd] <= TabDat;
      end
      r_code <= r_tab[w_rd_addr];
   end

   logic [25:0] r_s1_str;
   logic        r_s1_oor;

   always_ff @(posedge px_clk) begin
      if (rst) begin
         r_s1_str <= '0;
         r_s1_oor <= 1'b0;
      end else begin
         r_s1_str <= RGBStr_i;
         r_s1_oor <= w_oor;
      end
   end

   logic [3:0] w_code;
   logic [3:0] w_lx;
   logic [3:0] w_ly;
   logic [2:0] w_bg;
   logic [4:0] w_lx2;
   logic [4:0] w_ly2;
   logic [4:0] w_adx;
   logic [4:0] w_ady;
   logic [8:0] w_sq;
   logic       w_disc;
   logic       w_mouth;
   logic       w_ghost_body;
   logic       w_ghost_eye;
   logic       w_solid;
   logic [2:0] w_rgb;

   assign w_code = r_s1_oor ? 4'd0 : r_code;
   assign w_lx   = r_s1_str[16:13];
   assign w_ly   = r_s1_str[6:3];
   assign w_bg   = r_s1_str[25:23];
   assign w_lx2  = {w_lx, 1'b0};
   assign w_ly2  = {w_ly, 1'b0};

   // |2*l-15| without a signed intermediate; always odd, 1..15.
   assign w_adx  = w_lx[3] ? (w_lx2 - 5'd15) : (5'd15 - w_lx2);
   assign w_ady  = w_ly[3] ? (w_ly2 - 5'd15) : (5'd15 - w_ly2);
   assign w_sq   = {4'd0, w_adx} * {4'd0, w_adx} + {4'd0, w_ady} * {4'd0, w_ady};
   assign w_disc = (w_sq <= 9'd196);

   // Wedge opening to the left; 16-2*lx stays positive for lx <= 7.
   assign w_mouth = !w_lx[3] && (w_ady < (5'd16 - w_lx2));

   assign w_ghost_body = (w_ly >= 4'd2) && (w_lx >= 4'd2) && (w_lx <= 4'd13) &&
                         !((w_ly == 4'd15) && w_lx[0]);
   assign w_ghost_eye  = ((w_ly == 4'd5) || (w_ly == 4'd6)) &&
                         ((w_lx == 4'd4) || (w_lx == 4'd5) ||
                          (w_lx == 4'd10) || (w_lx == 4'd11));
   assign w_solid      = (w_lx >= 4'd1) && (w_lx <= 4'd14) &&
                         (w_ly >= 4'd1) && (w_ly <= 4'd14);

   always_comb begin
      w_rgb = w_bg;
      case (w_code)
         4'd0: w_rgb = w_bg;
         4'd1: begin
            if (w_ghost_eye) begin
               w_rgb = 3'b111;
            end else if (w_ghost_body) begin
               w_rgb = 3'b100;
            end
         end
         4'd2: begin
            if (w_disc) begin
               w_rgb = 3'b110;
            end
         end
         4'd3: begin
            if (w_disc && !w_mouth) begin
               w_rgb = 3'b110;
            end
         end
         default: begin
            if (w_solid) begin
               w_rgb = w_code[2:0];
            end
         end
      endcase
      if (!r_s1_str[0]) begin
         w_rgb = 3'b000;
      end
   end

   logic [25:0] r_s2_str;

   always_ff @(posedge px_clk) begin
      if (rst) begin
         r_s2_str <= '0;
      end else begin
         r_s2_str <= {w_rgb, r_s1_str[22:0]};
      end
   end

   assign RGBStr_o = r_s2_str;

endmodule

// File: tb/tb_pxs_tile_render.sv
// Bench for pxs_tile_render: directed and random pixel/table traffic checked against a
// per-pixel reference model of the tile table and glyph rules.
module tb_pxs_tile_render;

   logic        px_clk;
   logic        rst;
   logic [25:0] RGBStr_i;
   logic        write_en;
   logic [10:0] TabAdd;
   logic [3:0]  TabDat;
   logic [25:0] RGBStr_o;

   pxs_tile_render dut (
      .px_clk   (px_clk),
      .rst      (rst),
      .RGBStr_i (RGBStr_i),
      .write_en (write_en),
      .TabAdd   (TabAdd),
      .TabDat   (TabDat),
      .RGBStr_o (RGBStr_o)
   );

   initial px_clk = 1'b0;
   always #5 px_clk = ~px_clk;

   int          checks = 0;
   int          errors = 0;
   int          tab [1200];
   logic [25:0] pend_v = '0;
   int          pend_c = -1;
   string       pend_t = "init";

   function automatic logic [25:0] mk(input logic [2:0] rgb, input int xc, input int yc,
                                      input logic hs, input logic vs, input logic act);
      return {rgb, 10'(xc), 10'(yc), hs, vs, act};
   endfunction

   function automatic logic [2:0] glyph(input int code, input int lx, input int ly,
                                        input logic [2:0] bg);
      int dx;
      int dy;
      int ady;
      bit disc;
      dx   = 2 * lx - 15;
      dy   = 2 * ly - 15;
      ady  = (dy < 0) ? -dy : dy;
      disc = (dx * dx + dy * dy) <= 196;
      if (code == 0) return bg;
      if (code == 1) begin
         if ((ly == 5 || ly == 6) && (lx inside {4, 5, 10, 11})) return 3'b111;
         if (ly >= 2 && lx >= 2 && lx <= 13 && !(ly == 15 && (lx % 2) == 1)) return 3'b100;
         return bg;
      end
      if (code == 2) return disc ? 3'b110 : bg;
      if (code == 3) return (disc && !(lx <= 7 && ady < 16 - 2 * lx)) ? 3'b110 : bg;
      return (lx >= 1 && lx <= 14 && ly >= 1 && ly <= 14) ? 3'(code) : bg;
   endfunction

   function automatic logic [25:0] model_px(input logic [25:0] s);
      int xc;
      int yc;
      int code;
      logic [2:0] rgb;
      xc   = int'(s[22:13]);
      yc   = int'(s[12:3]);
      code = 0;
      if (xc < 640 && yc < 480) code = tab[(yc / 16) * 40 + xc / 16];
      rgb = glyph(code, xc % 16, yc % 16, s[25:23]);
      if (!s[0]) rgb = 3'b000;
      return {rgb, s[22:0]};
   endfunction

   // One clock: drive inputs, advance the two-deep model, check the output after the edge.
   // cst >= 0 additionally pins the output RGB of this pixel to a hand-derived constant.
   task automatic step(input logic r, input logic [25:0] s, input logic we,
                       input logic [10:0] a, input logic [3:0] d, input int cst,
                       input string tag);
      logic [25:0] exp_v;
      int          exp_c;
      string       exp_t;
      rst      = r;
      RGBStr_i = s;
      write_en = we;
      TabAdd   = a;
      TabDat   = d;
      exp_v  = r ? 26'd0 : pend_v;
      exp_c  = r ? -1 : pend_c;
      exp_t  = r ? {tag, "-rst"} : pend_t;
      pend_v = r ? 26'd0 : model_px(s);
      pend_c = r ? -1 : cst;
      pend_t = tag;
      if (we && a < 11'd1200) tab[a] = int'(d);
      @(posedge px_clk);
      #1;
      checks++;
      assert (RGBStr_o === exp_v) else begin
         errors++;
         $error("FAIL %s: RGBStr_o=%h expected %h", exp_t, RGBStr_o, exp_v);
      end
      if (exp_c >= 0) begin
         checks++;
         assert (RGBStr_o[25:23] === 3'(exp_c)) else begin
            errors++;
            $error("FAIL %s-rgb: rgb=%0d expected %0d", exp_t, RGBStr_o[25:23], exp_c);
         end
      end
   endtask

   task automatic wr(input int a, input int d);
      step(1'b0, 26'd0, 1'b1, 11'(a), 4'(d), -1, "wr");
   endtask

   task automatic px(input logic [2:0] rgb, input int xc, input int yc, input int cst,
                     input string tag);
      step(1'b0, mk(rgb, xc, yc, 1'b0, 1'b0, 1'b1), 1'b0, 11'd0, 4'd0, cst, tag);
   endtask

   task automatic flush();
      step(1'b0, 26'd0, 1'b0, 11'd0, 4'd0, -1, "flush");
      step(1'b0, 26'd0, 1'b0, 11'd0, 4'd0, -1, "flush");
   endtask

   initial begin
      int rows [9] = '{0, 1, 15, 16, 240, 479, 480, 490, 524};
      rst      = 1'b1;
      RGBStr_i = '0;
      write_en = 1'b0;
      TabAdd   = '0;
      TabDat   = '0;

      // Reset with random stream, then release with an empty table.
      for (int i = 0; i < 3; i++) step(1'b1, 26'($urandom), 1'b0, 11'd0, 4'd0, -1, "reset");
      for (int i = 0; i < 8; i++) step(1'b0, 26'($urandom), 1'b0, 11'd0, 4'd0, -1, "release");

      // Pass-through scan over selected frame rows, RGB=001, empty table.
      foreach (rows[k]) begin
         for (int x = 0; x < 800; x++) begin
            logic act;
            act = (x < 640) && (rows[k] < 480);
            step(1'b0, mk(3'b001, x, rows[k], (x >= 656 && x < 752),
                          (rows[k] == 490 || rows[k] == 491), act),
                 1'b0, 11'd0, 4'd0, act ? 1 : 0, "scan");
         end
      end
      flush();

      // Ghost at tile (14,38).
      wr(598, 1);
      px(3'b011, 612, 229, 7, "ghost_eye");
      px(3'b010, 610, 232, 4, "ghost_body");
      px(3'b010, 609, 239, 2, "ghost_edge");
      flush();

      // Pacman open then closed at tile (14,39).
      wr(599, 3);
      px(3'b001, 626, 231, 1, "pac_mouth");
      px(3'b001, 636, 231, 6, "pac_open");
      wr(599, 2);
      px(3'b001, 626, 231, 6, "pac_closed");
      flush();

      // Read-first collision at address 0.
      step(1'b0, mk(3'b101, 7, 7, 1'b0, 1'b0, 1'b1), 1'b1, 11'd0, 4'd2, 5, "collide_old");
      px(3'b101, 1, 7, 6, "collide_new");
      flush();

      // Ignored write, last table entry, out-of-range column aliasing addr 43.
      wr(1500, 5);
      wr(1199, 6);
      wr(43, 9);
      px(3'b011, 632, 472, 6, "tab_last");
      px(3'b011, 700, 5, 3, "oor_x");
      px(3'b011, 700, 500, 3, "oor_xy");
      flush();

      // Mid-stream reset flushes in-flight pixels; table survives.
      px(3'b010, 612, 229, 7, "pre_rst");
      step(1'b1, mk(3'b010, 612, 230, 1'b0, 1'b0, 1'b1), 1'b0, 11'd0, 4'd0, -1, "mid_rst");
      px(3'b010, 612, 229, 7, "post_rst");
      flush();

      // Random table writes and pixels with sporadic reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0),
              mk(3'($urandom), int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0)),
              1'($urandom), 11'($urandom_range(0, 1300)), 4'($urandom), -1, "random");
      end
      flush();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
